// File: rtl/dp_ram_be.sv
// Dual-port RAM with per-byte write enables, write-first bypass,
// configurable read latency and an optional zeroing sweep after reset.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   wr_en      : write request
//   wr_addr    : write address
//   wr_data    : write data
//   wr_be      : byte enables, bit i selects wr_data[8i+7:8i]
//   rd_en      : read request
//   rd_addr    : read address
//   rd_data    : read data, holds its value between completed reads
//   rd_valid   : one-cycle pulse qualifying rd_data
//   init_done  : high once the ports accept traffic
module dp_ram_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 4,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    init_done
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_n;
   logic [ADDR_WIDTH-1:0]   clr_q;
   logic [ADDR_WIDTH-1:0]   clr_n;
   logic                    clr_we;
   logic                    done_n;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    wr_acc;
   logic                    rd_acc;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic                    p_valid;
   logic [DATA_WIDTH-1:0]   p_data;

   // Control FSM: state, sweep pointer and init_done register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT;
         clr_q     <= '0;
         init_done <= 1'b0;
      end else begin
         state_q   <= state_n;
         clr_q     <= clr_n;
         init_done <= done_n;
      end
   end

   always_comb begin
      state_n = state_q;
      clr_n   = clr_q;
      clr_we  = 1'b0;
      done_n  = init_done;
      unique case (state_q)
         INIT: begin
            if (CLEAR_ON_RESET) begin
               clr_we = 1'b1;
               clr_n  = clr_q + ADDR_WIDTH'(1);
               if (clr_q == '1) begin
                  state_n = RUN;
                  done_n  = 1'b1;
               end
            end else begin
               state_n = RUN;
               done_n  = 1'b1;
            end
         end
         RUN: begin
            done_n = 1'b1;
         end
         default: begin
            state_n = INIT;
         end
      endcase
   end

   assign wr_acc = wr_en & init_done;
   assign rd_acc = rd_en & init_done;

   // The array itself has no reset; only the INIT sweep zeroes it.
   // The sweep is held off while rst is high so a long reset does not
   // keep rewriting address 0.
   always_ff @(posedge clk) begin
      if (clr_we && !rst) begin
         mem[clr_q] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Write-first bypass, resolved per byte.
   always_comb begin
      rd_word = mem[rd_addr];
      if (wr_acc && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline. p_* is the extra stage used when READ_LATENCY=2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_valid  <= 1'b0;
         p_data   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         p_valid <= rd_acc;
         if (rd_acc) begin
            p_data <= rd_word;
         end
         if (READ_LATENCY == 1) begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
               rd_data <= rd_word;
            end
         end else begin
            rd_valid <= p_valid;
            if (p_valid) begin
               rd_data <= p_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench for dp_ram_be, running READ_LATENCY=1 and =2
// instances side by side on identical stimulus.
module tb_dp_ram_be;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic [31:0] d1_data, d2_data;
   logic        d1_valid, d2_valid;
   logic        d1_done, d2_done;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   logic [31:0] mdl [16];
   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;

   dp_ram_be #(.READ_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d1_data), .rd_valid(d1_valid),
      .init_done(d1_done)
   );

   dp_ram_be #(.READ_LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d2_data), .rd_valid(d2_valid),
      .init_done(d2_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (d1_valid !== 1'b0) begin
         if (q1.size() == 0) begin
            chk("l1_spurious_valid", 32'(d1_valid), 32'd0);
         end else begin
            e = q1.pop_front();
            chk("l1_data", d1_data, e.d);
            chk("l1_latency", 32'(cyc), 32'(e.due));
         end
      end
      if (d2_valid !== 1'b0) begin
         if (q2.size() == 0) begin
            chk("l2_spurious_valid", 32'(d2_valid), 32'd0);
         end else begin
            e = q2.pop_front();
            chk("l2_data", d2_data, e.d);
            chk("l2_latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      q1.push_back('{d: v, due: cyc + 1});
      q2.push_back('{d: v, due: cyc + 2});
   endtask

   task automatic mdl_wr(input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      for (int i = 0; i < 4; i++)
         if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      step();
      wr_en = 1'b0;
      mdl_wr(a, d, be);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] v);
      rd_en = 1'b1; rd_addr = a;
      push(v);
      step();
      rd_en = 1'b0;
   endtask

   task automatic drain();
      repeat (4) step();
   endtask

   // Counts edges from rst release until init_done, optionally
   // hammering both ports while INIT is running.
   task automatic count_init(input string nm, input bit hammer);
      int n;
      n = 0;
      rst = 1'b0;
      while (d1_done !== 1'b1 && n < 40) begin
         if (hammer) begin
            wr_en = 1'b1; wr_addr = 4'(n); wr_data = 32'hFFFF_FFFF;
            wr_be = 4'hF; rd_en = 1'b1; rd_addr = 4'(n);
         end
         step();
         n++;
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk({nm, "_edges"}, 32'(n), 32'd16);
      chk({nm, "_l2_done"}, 32'(d2_done), 32'd1);
      for (int i = 0; i < 16; i++) mdl[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got %0d want finish", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      repeat (3) step();
      chk("rst_l1_data", d1_data, 32'h0);
      chk("rst_l1_valid", 32'(d1_valid), 32'd0);
      chk("rst_l1_done", 32'(d1_done), 32'd0);
      chk("rst_l2_done", 32'(d2_done), 32'd0);

      count_init("init1", 1'b0);
      for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
      drain();

      wr(4'd3, 32'hDEAD_BEEF, 4'hF);
      wr(4'd3, 32'h1122_3344, 4'b0101);
      rd(4'd3, 32'hDE22_BE44);
      drain();
      chk("hold_l1", d1_data, 32'hDE22_BE44);
      chk("hold_l2", d2_data, 32'hDE22_BE44);

      wr(4'd5, 32'hAAAA_AAAA, 4'hF);
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h5555_5555;
      wr_be = 4'b0011;
      rd_en = 1'b1; rd_addr = 4'd5;
      push(32'hAAAA_5555);
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      mdl_wr(4'd5, 32'h5555_5555, 4'b0011);

      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0BAD_F00D;
      wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd3;
      push(32'hDE22_BE44);
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      mdl_wr(4'd9, 32'h0BAD_F00D, 4'hF);
      rd(4'd9, 32'h0BAD_F00D);
      drain();

      for (int i = 0; i < 12; i++) begin
         v = $urandom;
         wr(4'($urandom_range(0, 15)), v, 4'($urandom_range(0, 15)));
      end
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = 4'(a);
         push(mdl[a]);
         step();
      end
      rd_en = 1'b0;
      drain();

      rd_en = 1'b1; rd_addr = 4'd3;
      step();
      rd_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_l2_data", d2_data, 32'h0);
      chk("arst_l2_valid", 32'(d2_valid), 32'd0);
      chk("arst_l2_done", 32'(d2_done), 32'd0);
      chk("arst_l1_data", d1_data, 32'h0);
      repeat (3) step();

      count_init("init2", 1'b1);
      for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
      drain();

      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("q2_empty", 32'(q2.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dp_ram_be.md
DP_RAM_BE -- requirements
Module: dp_ram_be

Interface
REQ-001: Parameter DATA_WIDTH, default 32; read/write data width in bits; SHALL be a multiple of 8.
REQ-002: Parameter ADDR_WIDTH, default 4; address width; memory depth SHALL be DEPTH = 2**ADDR_WIDTH words.
REQ-003: Parameter READ_LATENCY, default 1; legal values 1 or 2; edges from accepted read to valid data.
REQ-004: Parameter CLEAR_ON_RESET, default 1; 1 = zero all words after reset, 0 = contents undefined after reset.
REQ-005: clk  input  1  single clock; all state updates on its rising edge.
REQ-006: rst  input  1  asynchronous, active-high reset.
REQ-007: wr_en  input  1  write request.
REQ-008: wr_addr  input  ADDR_WIDTH  write address.
REQ-009: wr_data  input  DATA_WIDTH  write data.
REQ-010: wr_be  input  DATA_WIDTH/8  byte enables; bit i selects wr_data[8i+7:8i].
REQ-011: rd_en  input  1  read request.
REQ-012: rd_addr  input  ADDR_WIDTH  read address.
REQ-013: rd_data  output  DATA_WIDTH  read data.
REQ-014: rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015: init_done  output  1  high when ports accept traffic.

Function
REQ-016: Control FSM SHALL have states INIT and RUN; rst forces INIT.
REQ-017: With CLEAR_ON_RESET=1, INIT SHALL write zero to addresses 0..DEPTH-1, one per edge, in ascending order, then enter RUN; init_done rises on the edge that writes address DEPTH-1 (DEPTH edges after rst deassertion).
REQ-018: With CLEAR_ON_RESET=0, INIT SHALL enter RUN and raise init_done on the first edge after rst deassertion.
REQ-019: While init_done=0, wr_en and rd_en SHALL be ignored; no write occurs and rd_valid stays 0.
REQ-020: Write: at an edge with wr_en=1 and init_done=1, each byte of word wr_addr whose wr_be bit is 1 SHALL take wr_data's byte; other bytes unchanged; wr_be=0 writes nothing.
REQ-021: Read accepted at edge N when rd_en=1 and init_done=1; READ_LATENCY=1: rd_data/rd_valid update at edge N; READ_LATENCY=2: at edge N+1.
REQ-022: rd_valid SHALL be 1 for exactly one cycle per accepted read; one read per cycle sustained, no bubbles.
REQ-023: rd_data SHALL hold its last value when no read completes.
REQ-024: Same-cycle read and write to the same address SHALL be write-first per byte: enabled bytes return new data, disabled bytes return old data.
REQ-025: Reads and writes to different addresses in the same cycle SHALL both complete, independently.
REQ-026: Address arithmetic is unsigned ADDR_WIDTH bits; no out-of-range addresses exist.

Reset
REQ-027: Asserting rst SHALL immediately, without a clock edge, set rd_data=0, rd_valid=0, init_done=0, clear the read pipeline, and set FSM to INIT.
REQ-028: Reads in flight at rst assertion SHALL be dropped, never produce rd_valid.
REQ-029: rst asserted during INIT SHALL restart clearing from address 0 after deassertion.
REQ-030: Memory array contents SHALL NOT be cleared asynchronously; only the INIT sweep zeroes them.

Verification
REQ-031: Defaults; release rst; count edges -> init_done rises after exactly 16 edges; read every address -> all 32'h00000000.
REQ-032: Write addr 3 = 32'hDEADBEEF, be=4'hF; then write addr 3 = 32'h11223344, be=4'b0101; read addr 3 -> 32'hDE22BE44, rd_valid one cycle, latency per READ_LATENCY (run both 1 and 2).
REQ-033: Addr 5 holds 32'hAAAAAAAA; same cycle write 32'h55555555, be=4'b0011, and read addr 5 -> 32'hAAAA5555.
REQ-034: 16 back-to-back reads of addresses 0..15 after random writes -> 16 consecutive rd_valid pulses, data matching scoreboard.
REQ-035: Issue reads with READ_LATENCY=2, assert rst between acceptance and return -> rd_valid never pulses, rd_data=0, init_done=0 immediately.
REQ-036: Drive wr_en=1 and rd_en=1 during INIT -> no memory change (all zero after INIT), rd_valid stays 0.
